// File: rtl/coefficient_if.sv
// Sample/result bundle between the data loader, the coefficient fitter and the error stage.
// The loader (master) drives the EnCC strobe with x/y; the fitter (slave) returns B0/B1.
interface coefficient_if #(
    parameter int unsigned WIDTH = 20
);
    logic             EnCC;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] B0;
    logic [WIDTH-1:0] B1;

    modport master (output EnCC, x, y, input B0, B1);
    modport slave  (input EnCC, x, y, output B0, B1);
endinterface

// File: rtl/coefficient.sv
// Streaming least-squares line fitter: sums N (x,y) samples, then derives B1 and B0 with one shared restoring divider.
// Optional macro COEFFICIENT_ROUND_EN: adds a guard quotient bit so both results round to nearest, ties away from zero.
module coefficient #(
    parameter int unsigned WIDTH     = 20,
    parameter int unsigned FRAC      = 10,
    parameter int unsigned N_SAMPLES = 150,
    parameter int unsigned ACC_W     = 64
) (
    input  logic          clk,
    input  logic          rst,
    coefficient_if.slave  bus
);

`ifdef COEFFICIENT_ROUND_EN
    localparam int unsigned RND = 1;
`else
    localparam int unsigned RND = 0;
`endif
    localparam int unsigned ITER  = WIDTH + FRAC + RND;
    localparam int unsigned REM_W = ACC_W + 1;
    localparam int unsigned DSH_W = REM_W + ITER;
    localparam int unsigned CNT_W = $clog2(N_SAMPLES + 1);
    localparam int unsigned IT_W  = $clog2(ITER + 1);

    localparam logic signed [ACC_W-1:0] N_ACC = ACC_W'(N_SAMPLES);
    // B0 numerator is Q(2*FRAC); dividing by N scaled to Q(FRAC) lands the quotient in Q(FRAC)
    localparam logic [ACC_W-1:0] N_DIV   = ACC_W'(N_SAMPLES) << FRAC;
    localparam logic [ITER:0]    POS_LIM = (ITER+1)'((64'd1 << (WIDTH-1)) - 64'd1);
    localparam logic [ITER:0]    NEG_LIM = (ITER+1)'(64'd1 << (WIDTH-1));

    typedef enum logic [2:0] {
        ST_ACCUM,
        ST_PREP,
        ST_DIV1,
        ST_B0PREP,
        ST_DIV0,
        ST_OUT
    } state_e;

    state_e state_q, state_d;

    logic signed [ACC_W-1:0] sx_q, sx_d;
    logic signed [ACC_W-1:0] sy_q, sy_d;
    logic signed [ACC_W-1:0] sxx_q, sxx_d;
    logic signed [ACC_W-1:0] sxy_q, sxy_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic [REM_W-1:0] rem_q, rem_d;
    logic [DSH_W-1:0] dsh_q, dsh_d;
    logic [ITER-1:0]  quo_q, quo_d;
    logic [IT_W-1:0]  it_q, it_d;
    logic             neg_q, neg_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] q1_q, q1_d;
    logic [WIDTH-1:0] b0_q, b0_d;
    logic [WIDTH-1:0] b1_q, b1_d;

    logic signed [ACC_W-1:0] x_ext_c, y_ext_c;
    logic signed [ACC_W-1:0] num1_c, den1_c, num0_c, q1_ext_c;
    logic signed [ACC_W-1:0] ld_num_c;
    logic [ACC_W-1:0]        ld_den_c;
    logic                    ld_neg_c;
    logic [WIDTH-1:0]        q1_c, q0_c;
    logic [DSH_W-1:0]        rem_ext_c;
    logic                    fits_c, ovf_c;

    function automatic logic [ACC_W-1:0] mag(input logic signed [ACC_W-1:0] v);
        return v[ACC_W-1] ? ACC_W'(-v) : ACC_W'(v);
    endfunction

    // Applies rounding, sign and saturation to a raw quotient magnitude
    function automatic logic [WIDTH-1:0] finish_q(input logic [ITER-1:0] q, input logic neg,
                                                  input logic dz, input logic ovf);
        logic [ITER:0] m;
        logic [ITER:0] nm;
`ifdef COEFFICIENT_ROUND_EN
        m = ({1'b0, q} + (ITER+1)'(1)) >> 1;
`else
        m = {1'b0, q};
`endif
        nm = (ITER+1)'(0) - m;
        if (dz)
            return '0;
        else if (!neg)
            return (ovf || (m > POS_LIM)) ? {1'b0, {(WIDTH-1){1'b1}}} : WIDTH'(m);
        else
            return (ovf || (m > NEG_LIM)) ? {1'b1, {(WIDTH-1){1'b0}}} : WIDTH'(nm);
    endfunction

    assign x_ext_c = ACC_W'($signed(bus.x));
    assign y_ext_c = ACC_W'($signed(bus.y));

    // Slope terms: num1 in Q(3*FRAC), den1 in Q(2*FRAC), so q1 is Q(FRAC)
    assign num1_c = (N_ACC * sxy_q - sx_q * sy_q) <<< FRAC;
    assign den1_c = N_ACC * sxx_q - sx_q * sx_q;

    // Intercept uses the quantized, saturated slope
    assign q1_c     = finish_q(quo_q, neg_q, dz_q, ovf_q);
    assign q1_ext_c = ACC_W'($signed(q1_c));
    assign num0_c   = (sy_q <<< FRAC) - q1_ext_c * sx_q;
    assign q0_c     = finish_q(quo_q, neg_q, dz_q, ovf_q);

    assign ld_num_c = (state_q == ST_PREP) ? num1_c : num0_c;
    assign ld_den_c = (state_q == ST_PREP) ? mag(den1_c) : N_DIV;
    assign ld_neg_c = ld_num_c[ACC_W-1] ^ ((state_q == ST_PREP) & den1_c[ACC_W-1]);

    // Shifted-divisor restoring step; ovf flags a quotient too large for ITER bits
    assign rem_ext_c = DSH_W'(rem_q);
    assign fits_c    = rem_ext_c >= dsh_q;
    assign ovf_c     = (DSH_W+1)'(rem_q) >= {dsh_q, 1'b0};

    always_comb begin
        state_d = state_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        sxx_d   = sxx_q;
        sxy_d   = sxy_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dsh_d   = dsh_q;
        quo_d   = quo_q;
        it_d    = it_q;
        neg_d   = neg_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        q1_d    = q1_q;
        b0_d    = b0_q;
        b1_d    = b1_q;

        case (state_q)
            ST_ACCUM: begin
                if (bus.EnCC) begin
                    sx_d  = sx_q + x_ext_c;
                    sy_d  = sy_q + y_ext_c;
                    sxx_d = sxx_q + x_ext_c * x_ext_c;
                    sxy_d = sxy_q + x_ext_c * y_ext_c;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(N_SAMPLES - 1))
                        state_d = ST_PREP;
                end
            end

            ST_PREP, ST_B0PREP: begin
                rem_d = REM_W'(mag(ld_num_c)) << RND;
                dsh_d = DSH_W'(ld_den_c) << (ITER - 1);
                neg_d = ld_neg_c;
                dz_d  = (ld_den_c == '0);
                ovf_d = 1'b0;
                quo_d = '0;
                it_d  = '0;
                if (state_q == ST_B0PREP) begin
                    q1_d    = q1_c;
                    state_d = ST_DIV0;
                end else begin
                    state_d = ST_DIV1;
                end
            end

            ST_DIV1, ST_DIV0: begin
                if (it_q == '0)
                    ovf_d = ovf_c;
                if (fits_c) begin
                    rem_d = REM_W'(rem_ext_c - dsh_q);
                    quo_d = {quo_q[ITER-2:0], 1'b1};
                end else begin
                    quo_d = {quo_q[ITER-2:0], 1'b0};
                end
                dsh_d = dsh_q >> 1;
                it_d  = it_q + IT_W'(1);
                if (it_q == IT_W'(ITER - 1))
                    state_d = (state_q == ST_DIV1) ? ST_B0PREP : ST_OUT;
            end

            ST_OUT: begin
                b0_d    = q0_c;
                b1_d    = q1_q;
                sx_d    = '0;
                sy_d    = '0;
                sxx_d   = '0;
                sxy_d   = '0;
                cnt_d   = '0;
                state_d = ST_ACCUM;
            end

            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_ACCUM;
            sx_q    <= '0;
            sy_q    <= '0;
            sxx_q   <= '0;
            sxy_q   <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            dsh_q   <= '0;
            quo_q   <= '0;
            it_q    <= '0;
            neg_q   <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
            q1_q    <= '0;
            b0_q    <= '0;
            b1_q    <= '0;
        end else begin
            state_q <= state_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            sxx_q   <= sxx_d;
            sxy_q   <= sxy_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dsh_q   <= dsh_d;
            quo_q   <= quo_d;
            it_q    <= it_d;
            neg_q   <= neg_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
            q1_q    <= q1_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
        end
    end

    assign bus.B0 = b0_q;
    assign bus.B1 = b1_q;

endmodule

// File: tb/tb_coefficient.sv
// Directed bench for the coefficient fitter: N=4 instance for slope/intercept cases, N=3 instance for rounding.
module tb_coefficient;
    localparam int unsigned WIDTH = 20;
    localparam int unsigned FRAC  = 10;
`ifdef COEFFICIENT_ROUND_EN
    localparam int LAT = 65;
    localparam logic [WIDTH-1:0] RND_B0 = 20'h002AB;
`else
    localparam int LAT = 63;
    localparam logic [WIDTH-1:0] RND_B0 = 20'h002AA;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    coefficient_if #(.WIDTH(WIDTH)) if4 ();
    coefficient_if #(.WIDTH(WIDTH)) if3 ();

    coefficient #(.WIDTH(WIDTH), .FRAC(FRAC), .N_SAMPLES(4), .ACC_W(64)) u4 (
        .clk (clk),
        .rst (rst),
        .bus (if4)
    );

    coefficient #(.WIDTH(WIDTH), .FRAC(FRAC), .N_SAMPLES(3), .ACC_W(64)) u3 (
        .clk (clk),
        .rst (rst),
        .bus (if3)
    );

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Feeds four integer-valued samples (byte 0 first); returns just after the 4th capture edge
    task automatic feed4(input logic [3:0][7:0] xs, input logic [3:0][7:0] ys, input int gap);
        for (int i = 0; i < 4; i++) begin
            if4.EnCC = 1'b1;
            if4.x    = WIDTH'({xs[i], 10'd0});
            if4.y    = WIDTH'({ys[i], 10'd0});
            step(1);
            if (gap > 0 && i < 3) begin
                if4.EnCC = 1'b0;
                if4.x    = 20'h3FC00;
                if4.y    = 20'h3FC00;
                step(gap);
            end
        end
        if4.EnCC = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step(2);
        checks++; if (if4.B0 !== 20'h0) begin errors++; $display("FAIL reset_b0_n4 got %h exp %h", if4.B0, 20'h0); end
        checks++; if (if4.B1 !== 20'h0) begin errors++; $display("FAIL reset_b1_n4 got %h exp %h", if4.B1, 20'h0); end
        checks++; if (if3.B0 !== 20'h0) begin errors++; $display("FAIL reset_b0_n3 got %h exp %h", if3.B0, 20'h0); end
        checks++; if (if3.B1 !== 20'h0) begin errors++; $display("FAIL reset_b1_n3 got %h exp %h", if3.B1, 20'h0); end
        rst = 1'b1;
        step(1);
    endtask

    task automatic test_pos_slope();
        feed4({8'd4, 8'd3, 8'd2, 8'd1}, {8'd9, 8'd7, 8'd5, 8'd3}, 0);
        step(LAT - 1);
        checks++; if (if4.B1 !== 20'h0) begin errors++; $display("FAIL pos_early_b1 got %h exp %h", if4.B1, 20'h0); end
        checks++; if (if4.B0 !== 20'h0) begin errors++; $display("FAIL pos_early_b0 got %h exp %h", if4.B0, 20'h0); end
        step(1);
        checks++; if (if4.B1 !== 20'h00800) begin errors++; $display("FAIL pos_b1 got %h exp %h", if4.B1, 20'h00800); end
        checks++; if (if4.B0 !== 20'h00400) begin errors++; $display("FAIL pos_b0 got %h exp %h", if4.B0, 20'h00400); end
        step(10);
        checks++; if (if4.B1 !== 20'h00800) begin errors++; $display("FAIL pos_hold_b1 got %h exp %h", if4.B1, 20'h00800); end
    endtask

    task automatic test_neg_slope();
        feed4({8'd4, 8'd3, 8'd2, 8'd1}, {8'd1, 8'd2, 8'd3, 8'd4}, 0);
        step(LAT - 1);
        checks++; if (if4.B1 !== 20'h00800) begin errors++; $display("FAIL neg_early_b1 got %h exp %h", if4.B1, 20'h00800); end
        step(1);
        checks++; if (if4.B1 !== 20'hFFC00) begin errors++; $display("FAIL neg_b1 got %h exp %h", if4.B1, 20'hFFC00); end
        checks++; if (if4.B0 !== 20'h01400) begin errors++; $display("FAIL neg_b0 got %h exp %h", if4.B0, 20'h01400); end
    endtask

    task automatic test_degenerate();
        feed4({8'd1, 8'd1, 8'd1, 8'd1}, {8'd4, 8'd3, 8'd2, 8'd1}, 0);
        step(LAT);
        checks++; if (if4.B1 !== 20'h00000) begin errors++; $display("FAIL degen_b1 got %h exp %h", if4.B1, 20'h00000); end
        checks++; if (if4.B0 !== 20'h00A00) begin errors++; $display("FAIL degen_b0 got %h exp %h", if4.B0, 20'h00A00); end
    endtask

    task automatic test_gaps();
        feed4({8'd4, 8'd3, 8'd2, 8'd1}, {8'd9, 8'd7, 8'd5, 8'd3}, 3);
        step(LAT);
        checks++; if (if4.B1 !== 20'h00800) begin errors++; $display("FAIL gaps_b1 got %h exp %h", if4.B1, 20'h00800); end
        checks++; if (if4.B0 !== 20'h00400) begin errors++; $display("FAIL gaps_b0 got %h exp %h", if4.B0, 20'h00400); end
    endtask

    task automatic test_reset_abort();
        // Two samples of the negative set, then reset discards them
        if4.EnCC = 1'b1; if4.x = 20'h00400; if4.y = 20'h01000; step(1);
        if4.EnCC = 1'b1; if4.x = 20'h00800; if4.y = 20'h00C00; step(1);
        if4.EnCC = 1'b0;
        rst = 1'b0;
        step(1);
        checks++; if (if4.B1 !== 20'h0) begin errors++; $display("FAIL abort_b1 got %h exp %h", if4.B1, 20'h0); end
        checks++; if (if4.B0 !== 20'h0) begin errors++; $display("FAIL abort_b0 got %h exp %h", if4.B0, 20'h0); end
        rst = 1'b1;
        feed4({8'd4, 8'd3, 8'd2, 8'd1}, {8'd9, 8'd7, 8'd5, 8'd3}, 0);
        step(LAT);
        checks++; if (if4.B1 !== 20'h00800) begin errors++; $display("FAIL abort_refit_b1 got %h exp %h", if4.B1, 20'h00800); end
        checks++; if (if4.B0 !== 20'h00400) begin errors++; $display("FAIL abort_refit_b0 got %h exp %h", if4.B0, 20'h00400); end
        // Reset in the middle of a divide kills the pending result
        feed4({8'd4, 8'd3, 8'd2, 8'd1}, {8'd1, 8'd2, 8'd3, 8'd4}, 0);
        step(20);
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        checks++; if (if4.B1 !== 20'h0) begin errors++; $display("FAIL abort_div_b1 got %h exp %h", if4.B1, 20'h0); end
        step(LAT);
        checks++; if (if4.B1 !== 20'h0) begin errors++; $display("FAIL abort_div_late_b1 got %h exp %h", if4.B1, 20'h0); end
        checks++; if (if4.B0 !== 20'h0) begin errors++; $display("FAIL abort_div_late_b0 got %h exp %h", if4.B0, 20'h0); end
    endtask

    task automatic test_rounding();
        if3.EnCC = 1'b1; if3.x = 20'h00400; if3.y = 20'h00400; step(1);
        if3.EnCC = 1'b1; if3.x = 20'h00800; if3.y = 20'h00800; step(1);
        if3.EnCC = 1'b1; if3.x = 20'h00C00; if3.y = 20'h00800; step(1);
        if3.EnCC = 1'b0;
        step(LAT);
        checks++; if (if3.B1 !== 20'h00200) begin errors++; $display("FAIL round_b1 got %h exp %h", if3.B1, 20'h00200); end
        checks++; if (if3.B0 !== RND_B0) begin errors++; $display("FAIL round_b0 got %h exp %h", if3.B0, RND_B0); end
    endtask

    task automatic test_back_to_back();
        feed4({8'd4, 8'd3, 8'd2, 8'd1}, {8'd9, 8'd7, 8'd5, 8'd3}, 0);
        // Strobe stays high with junk through the whole compute phase
        if4.EnCC = 1'b1; if4.x = 20'h01C00; if4.y = 20'hFF400;
        step(LAT);
        checks++; if (if4.B1 !== 20'h00800) begin errors++; $display("FAIL b2b_first_b1 got %h exp %h", if4.B1, 20'h00800); end
        checks++; if (if4.B0 !== 20'h00400) begin errors++; $display("FAIL b2b_first_b0 got %h exp %h", if4.B0, 20'h00400); end
        for (int i = 0; i < 4; i++) begin
            if4.x = WIDTH'((i + 1) * 1024);
            if4.y = WIDTH'((4 - i) * 1024);
            step(1);
        end
        if4.x = 20'h01C00; if4.y = 20'hFF400;
        step(LAT);
        checks++; if (if4.B1 !== 20'hFFC00) begin errors++; $display("FAIL b2b_second_b1 got %h exp %h", if4.B1, 20'hFFC00); end
        checks++; if (if4.B0 !== 20'h01400) begin errors++; $display("FAIL b2b_second_b0 got %h exp %h", if4.B0, 20'h01400); end
        if4.EnCC = 1'b0;
        step(2);
    endtask

    initial begin
        rst      = 1'b0;
        if4.EnCC = 1'b0; if4.x = '0; if4.y = '0;
        if3.EnCC = 1'b0; if3.x = '0; if3.y = '0;
        test_reset();
        test_pos_slope();
        test_neg_slope();
        test_degenerate();
        test_gaps();
        test_reset_abort();
        test_rounding();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
